display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for the six-digit seven-segment time display. It drives the 3-bit digit select into the BCD digit mux and the active-low anode enables on the board. It snapshots the 24-bit BCD time once per frame so the display never tears, and it inserts a dead band between digits to suppress ghosting. It also blinks selected digits during time/alarm setting and optionally suppresses a leading zero in the hours-tens digit.

## Interface
- DIV_CYC, 100000: clock cycles per digit slot, including the dead band; must be > BLANK_CYC.
- BLANK_CYC, 1000: cycles at the start of each slot with all anodes off; must be ≥ 1.
- BLINK_FRAMES, 83: frames per blink half-period (≈0.5 s at 100 MHz).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- count  in  24  BCD time: [3:0] sec units, [7:4] sec tens, [11:8] min units, [15:12] min tens, [19:16] hr units, [23:20] hr tens.
- blink_mask  in  6  bit i set = digit i blinks.
- lz_en  in  1  suppress hr-tens digit when its value is 0.
- select  out  3  current digit index 0..5 (0 = sec units), drives the digit mux.
- digit  out  4  BCD value of the current digit from the frame snapshot.
- anode  out  8  active-low digit enables; bits [7:6] are always 1.
- frame_start  out  1  one-cycle pulse when a new snapshot is loaded.

## Operation
- Slot counter cnt runs 0..DIV_CYC-1, then wraps to 0. select increments on each wrap, and 5 wraps to 0.
- Two-state FSM per slot:
  - BLANK: cnt < BLANK_CYC, anode = 8'hFF.
  - DRIVE: cnt ≥ BLANK_CYC, anode[select] = 0 unless the digit is suppressed.
  - Transitions: BLANK→DRIVE when cnt reaches BLANK_CYC. DRIVE→BLANK on slot wrap.
- Frame boundary is a slot wrap with select==5. On it:
  - snap ← count.
  - frame_start pulses.
  - The frame counter advances. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- digit = snap nibble indexed by select. Values 10..15 pass through unchanged; decoding them is the decoder's concern.
- Suppression forces all anodes high during DRIVE when either condition holds:
  - blink_mask[select] && blink_phase==1, or
  - lz_en && select==5 && snap[23:20]==0.
- blink_mask and lz_en are sampled live each cycle. count is sampled only at frame boundaries.
- Reset values: cnt 0, select 0, state BLANK, anode 8'hFF, digit 0, snap 0, blink_phase 0, frame counter 0, frame_start 0.
- Reset asserted mid-slot returns everything to reset values immediately. Before the first frame boundary the display shows 000000.

## Timing
- All outputs are registered with no combinational input-to-output path.
- Cycle 0 is the first rising edge after reset_n deasserts.
  - Slot n occupies cycles [n·DIV_CYC, (n+1)·DIV_CYC−1].
  - anode is 8'hFF for the first BLANK_CYC cycles of each slot.
  - anode is active for the remaining DIV_CYC−BLANK_CYC cycles.
- select and digit change on the same edge that starts a slot. Both are stable for the entire BLANK period before any anode enables.
- Frame period is 6·DIV_CYC. The cycle select becomes 0 is the same cycle frame_start is high and snap and digit hold the new value.
- A count change mid-frame appears on the display at the next frame boundary. Latency is at most 6·DIV_CYC cycles.
- blink_phase changes only at frame boundaries, so a digit never blinks partway through its slot.

## Structure
- Shared package display_pkg holds NUM_DIGITS=6, ANODE_OFF=8'hFF, the digit index constants (SEC_U=0 … HR_T=5) and the scan state enum {BLANK, DRIVE}.
- One sub-module, scan_prescaler: cnt plus its wrap tick and the BLANK/DRIVE flag, parameterized by DIV_CYC and BLANK_CYC.
- The top level holds select, snap, the blink frame counter and the anode/digit registers.

## Test plan
All scenarios use DIV_CYC=8, BLANK_CYC=2, BLINK_FRAMES=2.
- Reset: hold reset_n=0 with count=24'h123456 → anode=FF, select=0, digit=0, frame_start=0. Release → cycles 0–1 anode=FF, cycles 2–7 anode=FE, digit=0.
- Scan and snapshot: count=24'h123456 held → first frame_start at cycle 48, then digits 6,5,4,3,2,1 on select 0..5. anode=FE,FD,FB,F7,EF,DF in DRIVE and FF in BLANK. Bits [7:6] are never 0.
- Tear-free update: change count to 24'h000000 at cycle 60 → select 1..5 still show 5,4,3,2,1. Zeros appear from cycle 96.
- Blink: blink_mask=6'b000011 → anode for digits 0–1 is FF in DRIVE on alternating 2-frame windows. Digits 2–5 are unaffected. Toggles occur only at frame boundaries.
- Leading zero: snap=24'h095959. lz_en=1 gives anode=FF throughout the select=5 slot. lz_en=0 gives anode=DF in DRIVE with digit=0.
- Mid-slot reset: assert reset_n=0 at cycle 21 → anode=FF and select=0 the same cycle, asynchronously. After release, the sequence restarts at cycle 0 with snap=0.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, scan state enum and nibble helper for the six-digit
// seven-segment scan controller.
package display_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam logic [7:0] ANODE_OFF  = 8'hFF;

  localparam logic [2:0] SEC_U = 3'd0;
  localparam logic [2:0] SEC_T = 3'd1;
  localparam logic [2:0] MIN_U = 3'd2;
  localparam logic [2:0] MIN_T = 3'd3;
  localparam logic [2:0] HR_U  = 3'd4;
  localparam logic [2:0] HR_T  = 3'd5;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [3:0] bcd_nibble(input logic [23:0] t, input logic [2:0] idx);
    logic [3:0] n;
    case (idx)
      SEC_U:   n = t[3:0];
      SEC_T:   n = t[7:4];
      MIN_U:   n = t[11:8];
      MIN_T:   n = t[15:12];
      HR_U:    n = t[19:16];
      HR_T:    n = t[23:20];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Display bus: BCD time and blink/zero controls in, digit select/value,
// anode enables and frame pulse out.
interface display_scan_ctrl_if;
  logic [23:0] count;
  logic [5:0]  blink_mask;
  logic        lz_en;
  logic [2:0]  select;
  logic [3:0]  digit;
  logic [7:0]  anode;
  logic        frame_start;

  // master: the scan controller; slave: time source and display board.
  modport master (
    input  count, blink_mask, lz_en,
    output select, digit, anode, frame_start
  );

  modport slave (
    output count, blink_mask, lz_en,
    input  select, digit, anode, frame_start
  );
endinterface

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// Digit-slot counter with wrap tick and BLANK/DRIVE sequencing.
// nxt_state_o is the state the slot will be in after this edge.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int DIV_CYC   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        wrap_o,
  output scan_state_e nxt_state_o
);

  localparam int               CNT_W     = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  scan_state_e      state_q, state_d;

  assign wrap_o      = (cnt_q == CNT_LAST);
  assign nxt_state_o = state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      state_q <= BLANK;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    cnt_d   = wrap_o ? '0 : cnt_q + CNT_W'(1);
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_d == BLANK_END) state_d = DRIVE;
      DRIVE:   if (wrap_o)             state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit scan controller: per-frame snapshot of the BCD time, digit select,
// dead-banded active-low anodes, blink and leading-zero suppression.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV_CYC      = 100000,
  parameter int BLANK_CYC    = 1000,
  parameter int BLINK_FRAMES = 83
) (
  input  logic                clk,
  input  logic                reset_n,
  display_scan_ctrl_if.master bus
);

  localparam int              FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic        wrap;
  scan_state_e nxt_state;

  scan_prescaler #(
    .DIV_CYC   (DIV_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescaler (
    .clk         (clk),
    .reset_n     (reset_n),
    .wrap_o      (wrap),
    .nxt_state_o (nxt_state)
  );

  logic [2:0]      sel_q, sel_d;
  logic [23:0]     snap_q, snap_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            phase_q, phase_d;
  logic [7:0]      anode_q, anode_d;
  logic [3:0]      digit_q, digit_d;
  logic            fs_q, fs_d;
  logic            frame_edge;
  logic            suppress;
  logic [7:0]      mask_ext;

  assign bus.select      = sel_q;
  assign bus.digit       = digit_q;
  assign bus.anode       = anode_q;
  assign bus.frame_start = fs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= SEC_U;
      snap_q  <= '0;
      fc_q    <= '0;
      phase_q <= 1'b0;
      anode_q <= ANODE_OFF;
      digit_q <= 4'h0;
      fs_q    <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      snap_q  <= snap_d;
      fc_q    <= fc_d;
      phase_q <= phase_d;
      anode_q <= anode_d;
      digit_q <= digit_d;
      fs_q    <= fs_d;
    end
  end

  // Outputs are registered from next-state values so select, digit and the
  // anodes all change on the very edge that starts a slot.
  always_comb begin
    frame_edge = wrap && (sel_q == HR_T);

    sel_d = sel_q;
    if (wrap) sel_d = frame_edge ? SEC_U : sel_q + 3'd1;

    snap_d  = frame_edge ? bus.count : snap_q;
    fc_d    = fc_q;
    phase_d = phase_q;
    if (frame_edge) begin
      if (fc_q == FC_LAST) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end

    mask_ext = {2'b00, bus.blink_mask};
    suppress = (mask_ext[sel_d] && phase_d) ||
               (bus.lz_en && (sel_d == HR_T) && (snap_d[23:20] == 4'h0));

    anode_d = ANODE_OFF;
    if ((nxt_state == DRIVE) && !suppress) anode_d = ~(8'h01 << sel_d);

    digit_d = bcd_nibble(snap_d, sel_d);
    fs_d    = frame_edge;
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: per-cycle expectations from a
// slot/frame arithmetic model, compared by an independent negedge monitor.
module tb_display_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int BF    = 2;

  typedef struct packed {
    int         cyc;
    logic [2:0] sel;
    logic [3:0] dig;
    logic [7:0] an;
    logic       fs;
  } exp_t;

  logic clk;
  logic reset_n;
  logic chk_en;
  int   t;
  int   n_chk;
  int   n_fail;

  exp_t        exp_q[$];
  logic [23:0] cnt_h[$];
  logic [5:0]  bm_h[$];
  logic        lz_h[$];

  display_scan_ctrl_if bus();

  display_scan_ctrl #(
    .DIV_CYC      (DIV),
    .BLANK_CYC    (BLANK),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs in cycle cyc (counted from reset release) from slot/frame arithmetic.
  function automatic exp_t model(input int cyc);
    exp_t        e;
    int          slot, pos, sel, f;
    logic [23:0] snap;
    logic [5:0]  m;
    logic        l;
    bit          sup;
    slot  = cyc / DIV;
    pos   = cyc % DIV;
    sel   = slot % 6;
    f     = slot / 6;
    snap  = (f == 0) ? 24'h0 : cnt_h[6 * DIV * f - 1];
    e.cyc = cyc;
    e.sel = 3'(sel);
    e.dig = 4'((snap >> (4 * sel)) & 24'hF);
    e.fs  = (cyc > 0) && (pos == 0) && (sel == 0);
    e.an  = 8'hFF;
    if (pos >= BLANK) begin
      m   = bm_h[cyc - 1];
      l   = lz_h[cyc - 1];
      sup = (m[sel] && (((f / BF) % 2) == 1)) ||
            (l && (sel == 5) && (snap[23:20] == 4'h0));
      if (!sup) e.an = ~(8'h01 << sel);
    end
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.cyc = -1;
    e.sel = 3'd0;
    e.dig = 4'h0;
    e.an  = 8'hFF;
    e.fs  = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", t);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("select",      e.cyc, 32'(bus.select),      32'(e.sel));
        check("digit",       e.cyc, 32'(bus.digit),       32'(e.dig));
        check("anode",       e.cyc, 32'(bus.anode),       32'(e.an));
        check("frame_start", e.cyc, 32'(bus.frame_start), 32'(e.fs));
      end
    end
  end

  task automatic hold_reset(input int n);
    reset_n = 1'b0;
    repeat (n) begin
      exp_q.push_back(reset_exp());
      bus.count = 24'($urandom);
      @(posedge clk);
      #1;
    end
    cnt_h.delete();
    bm_h.delete();
    lz_h.delete();
    t       = 0;
    reset_n = 1'b1;
  endtask

  task automatic step(input logic [23:0] c, input logic [5:0] m, input logic l);
    exp_q.push_back(model(t));
    bus.count      = c;
    bus.blink_mask = m;
    bus.lz_en      = l;
    cnt_h.push_back(c);
    bm_h.push_back(m);
    lz_h.push_back(l);
    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    t              = 0;
    chk_en         = 1'b0;
    reset_n        = 1'b0;
    bus.count      = 24'h123456;
    bus.blink_mask = 6'b0;
    bus.lz_en      = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    hold_reset(3);

    // Scan, snapshot at cycle 48, count cleared mid-frame at cycle 60.
    while (t < 60)  step(24'h123456, 6'b0, 1'b0);
    while (t < 150) step(24'h000000, 6'b0, 1'b0);

    // Blink digits 0-1 over several 2-frame windows.
    repeat (8 * 6 * DIV) step(24'($urandom), 6'b000011, 1'b0);

    // Leading zero on hours tens, suppressed then shown.
    repeat (3 * 6 * DIV) step(24'h095959, 6'b0, 1'b1);
    repeat (2 * 6 * DIV) step(24'h095959, 6'b0, 1'b0);

    // Random everything, masks changing every cycle.
    repeat (20 * 6 * DIV) step(24'($urandom), 6'($urandom), 1'($urandom));

    // Reset asserted in the middle of slot 2.
    hold_reset(2);
    while (t < 21) step(24'($urandom), 6'($urandom), 1'($urandom));
    hold_reset(2);
    repeat (10 * 6 * DIV) step(24'($urandom), 6'($urandom), 1'($urandom));

    chk_en = 1'b0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
